// File: rtl/pipeline_pkg.sv
// Shared types and constants for the writeback stage and its load queue.
package pipeline_pkg;

    localparam int REG_W = 5;
    localparam int DATA_W = 32;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic              valid;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] val;
    } wb_entry_t;

endpackage

// File: rtl/wb_load_queue.sv
// In-order circular buffer of pending load writebacks with kill-by-rd.
// Youngest-match lookup ports exist only when WB_FORWARD_EN is defined.
module wb_load_queue
    import pipeline_pkg::*;
#(
    parameter int LQ_DEPTH = 4,
    parameter int LQ_AW    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  wb_entry_t         push_entry,
    input  logic              pop,
    input  logic              kill_en,
    input  logic [REG_W-1:0]  kill_rd,
`ifdef WB_FORWARD_EN
    input  logic [REG_W-1:0]  look_rd0,
    input  logic [REG_W-1:0]  look_rd1,
    output logic              look_hit0,
    output logic [DATA_W-1:0] look_val0,
    output logic              look_hit1,
    output logic [DATA_W-1:0] look_val1,
`endif
    output wb_entry_t         head_entry,
    output logic [LQ_AW:0]    count
);

    localparam logic [LQ_AW:0]   CNT_ONE = (LQ_AW+1)'(1);
    localparam logic [LQ_AW-1:0] PTR_ONE = LQ_AW'(1);

    wb_entry_t        mem_q [LQ_DEPTH];
    wb_entry_t        mem_d [LQ_DEPTH];
    logic [LQ_AW-1:0] head_q, head_d;
    logic [LQ_AW-1:0] tail_q, tail_d;
    logic [LQ_AW:0]   count_q, count_d;

    // Kill applies to every slot; stale slots outside the live window are harmless.
    always_comb begin
        for (int i = 0; i < LQ_DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (kill_en && mem_q[i].rd == kill_rd) begin
                mem_d[i].valid = 1'b0;
            end
        end
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) begin
            mem_d[tail_q] = push_entry;
            tail_d        = tail_q + PTR_ONE;
        end
        if (pop) begin
            head_d = head_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LQ_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < LQ_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_entry = mem_q[head_q];
    assign count      = count_q;

`ifdef WB_FORWARD_EN
    logic [LQ_AW-1:0] look_idx;

    // Walk oldest to youngest so the last match found is the youngest one.
    always_comb begin
        look_hit0 = 1'b0;
        look_val0 = '0;
        look_hit1 = 1'b0;
        look_val1 = '0;
        look_idx  = '0;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            look_idx = head_q + LQ_AW'(i);
            if ((LQ_AW+1)'(i) < count_q && mem_q[look_idx].valid) begin
                if (mem_q[look_idx].rd == look_rd0) begin
                    look_hit0 = 1'b1;
                    look_val0 = mem_q[look_idx].val;
                end
                if (mem_q[look_idx].rd == look_rd1) begin
                    look_hit1 = 1'b1;
                    look_val1 = mem_q[look_idx].val;
                end
            end
        end
    end
`endif

endmodule

// File: rtl/pipeline_writeback.sv
// Writeback stage: arbitrates ALU and load results onto one regfile port.
// Optional register forwarding is enabled by defining WB_FORWARD_EN.
module pipeline_writeback
    import pipeline_pkg::*;
#(
    parameter int LQ_DEPTH = 4,
    parameter int LQ_AW    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [REG_W-1:0]  alu_rd,
    input  logic [DATA_W-1:0] alu_val,
    input  logic              ld_valid,
    input  logic [REG_W-1:0]  ld_rd,
    input  logic [DATA_W-1:0] ld_val,
    output logic              ld_ready,
    output logic              we,
    output logic [REG_W-1:0]  windex,
    output logic [DATA_W-1:0] win,
    output logic [LQ_AW:0]    lq_count,
    input  logic [REG_W-1:0]  rindex0,
    input  logic [REG_W-1:0]  rindex1,
    output logic              fwd0_hit,
    output logic [DATA_W-1:0] fwd0_val,
    output logic              fwd1_hit,
    output logic [DATA_W-1:0] fwd1_val
);

    localparam logic [LQ_AW:0] LQ_FULL = (LQ_AW+1)'(LQ_DEPTH);

    wb_entry_t         head_entry;
    wb_entry_t         push_entry;
    logic [LQ_AW:0]    lq_count_w;
    logic              lq_empty;
    logic              alu_go;
    logic              ld_accept;
    logic              load_live;
    logic              push;
    logic              pop;
    logic              we_q, we_d;
    logic [REG_W-1:0]  windex_q, windex_d;
    logic [DATA_W-1:0] win_q, win_d;

    assign ld_ready  = (lq_count_w < LQ_FULL);
    assign ld_accept = ld_valid & ld_ready;
    assign lq_empty  = (lq_count_w == '0);
    assign alu_go    = alu_valid && (alu_rd != REG_ZERO);
    // A same-cycle ALU write to the same rd makes the accepted load dead on arrival.
    assign load_live = ld_accept && (ld_rd != REG_ZERO) && !(alu_go && (ld_rd == alu_rd));

    assign push_entry = '{valid: 1'b1, rd: ld_rd, val: ld_val};

    always_comb begin
        we_d     = 1'b0;
        windex_d = '0;
        win_d    = '0;
        push     = 1'b0;
        pop      = 1'b0;
        if (alu_go) begin
            we_d     = 1'b1;
            windex_d = alu_rd;
            win_d    = alu_val;
            push     = load_live;
        end else if (!lq_empty) begin
            pop      = 1'b1;
            push     = load_live;
            if (head_entry.valid) begin
                we_d     = 1'b1;
                windex_d = head_entry.rd;
                win_d    = head_entry.val;
            end
        end else if (load_live) begin
            we_d     = 1'b1;
            windex_d = ld_rd;
            win_d    = ld_val;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q     <= 1'b0;
            windex_q <= '0;
            win_q    <= '0;
        end else begin
            we_q     <= we_d;
            windex_q <= windex_d;
            win_q    <= win_d;
        end
    end

    assign we       = we_q;
    assign windex   = windex_q;
    assign win      = win_q;
    assign lq_count = lq_count_w;

`ifdef WB_FORWARD_EN
    logic              q_hit0, q_hit1;
    logic [DATA_W-1:0] q_val0, q_val1;
    logic              r_hit0, r_hit1;

    wb_load_queue #(.LQ_DEPTH(LQ_DEPTH), .LQ_AW(LQ_AW)) u_lq (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .kill_en    (alu_go),
        .kill_rd    (alu_rd),
        .look_rd0   (rindex0),
        .look_rd1   (rindex1),
        .look_hit0  (q_hit0),
        .look_val0  (q_val0),
        .look_hit1  (q_hit1),
        .look_val1  (q_val1),
        .head_entry (head_entry),
        .count      (lq_count_w)
    );

    assign r_hit0 = we_q && (windex_q == rindex0);
    assign r_hit1 = we_q && (windex_q == rindex1);

    // Queued loads are younger than the value already on the write port.
    always_comb begin
        fwd0_hit = 1'b0;
        fwd0_val = '0;
        fwd1_hit = 1'b0;
        fwd1_val = '0;
        if (rindex0 != REG_ZERO) begin
            fwd0_hit = q_hit0 | r_hit0;
            fwd0_val = q_hit0 ? q_val0 : (r_hit0 ? win_q : '0);
        end
        if (rindex1 != REG_ZERO) begin
            fwd1_hit = q_hit1 | r_hit1;
            fwd1_val = q_hit1 ? q_val1 : (r_hit1 ? win_q : '0);
        end
    end
`else
    logic fwd_unused;

    wb_load_queue #(.LQ_DEPTH(LQ_DEPTH), .LQ_AW(LQ_AW)) u_lq (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .kill_en    (alu_go),
        .kill_rd    (alu_rd),
        .head_entry (head_entry),
        .count      (lq_count_w)
    );

    assign fwd_unused = ^{rindex0, rindex1};
    assign fwd0_hit   = 1'b0;
    assign fwd0_val   = '0;
    assign fwd1_hit   = 1'b0;
    assign fwd1_val   = '0;
`endif

endmodule

// File: tb/tb_pipeline_writeback.sv
// Directed self-checking bench for pipeline_writeback (covers both WB_FORWARD_EN builds).
module tb_pipeline_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_val;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_val;
    logic        ld_ready;
    logic        we;
    logic [4:0]  windex;
    logic [31:0] win;
    logic [2:0]  lq_count;
    logic [4:0]  rindex0;
    logic [4:0]  rindex1;
    logic        fwd0_hit;
    logic [31:0] fwd0_val;
    logic        fwd1_hit;
    logic [31:0] fwd1_val;

    int checks = 0;
    int failures = 0;

    pipeline_writeback dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_val   (alu_val),
        .ld_valid  (ld_valid),
        .ld_rd     (ld_rd),
        .ld_val    (ld_val),
        .ld_ready  (ld_ready),
        .we        (we),
        .windex    (windex),
        .win       (win),
        .lq_count  (lq_count),
        .rindex0   (rindex0),
        .rindex1   (rindex1),
        .fwd0_hit  (fwd0_hit),
        .fwd0_val  (fwd0_val),
        .fwd1_hit  (fwd1_hit),
        .fwd1_val  (fwd1_val)
    );

    always #5 clk = ~clk;

    // Drives one cycle's worth of ALU and load inputs.
    task automatic applyStimulus(input logic av, input logic [4:0] ar, input logic [31:0] aval,
                                 input logic lv, input logic [4:0] lr, input logic [31:0] lval);
        alu_valid = av;
        alu_rd    = ar;
        alu_val   = aval;
        ld_valid  = lv;
        ld_rd     = lr;
        ld_val    = lval;
    endtask

    // Compares one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Advances to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks the registered write port in one call.
    task automatic checkWrite(input string tag, input logic ewe, input logic [4:0] eidx, input logic [31:0] eval);
        checkOutput({tag, "_we"}, 32'(we), 32'(ewe));
        if (ewe) begin
            checkOutput({tag, "_windex"}, 32'(windex), 32'(eidx));
            checkOutput({tag, "_win"}, win, eval);
        end
    endtask

    logic [4:0]  drain_rd  [5];
    logic [31:0] drain_val [5];

    initial begin
        rst     = 1'b1;
        rindex0 = 5'd0;
        rindex1 = 5'd0;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        tick();
        checkOutput("rst_we", 32'(we), 32'd0);
        checkOutput("rst_windex", 32'(windex), 32'd0);
        checkOutput("rst_win", win, 32'd0);
        checkOutput("rst_count", 32'(lq_count), 32'd0);
        checkOutput("rst_ready", 32'(ld_ready), 32'd1);
        rst = 1'b0;

        $display("[TB] ALU only");
        applyStimulus(1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'h0);
        tick();
        checkWrite("alu5", 1'b1, 5'd5, 32'h11);
        applyStimulus(1'b1, 5'd0, 32'h22, 1'b0, 5'd0, 32'h0);
        tick();
        checkWrite("alu_r0", 1'b0, 5'd0, 32'h0);

        $display("[TB] ALU and load same cycle");
        applyStimulus(1'b1, 5'd3, 32'd7, 1'b1, 5'd4, 32'd9);
        tick();
        checkWrite("same_alu", 1'b1, 5'd3, 32'd7);
        checkOutput("same_cnt1", 32'(lq_count), 32'd1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        checkWrite("same_ld", 1'b1, 5'd4, 32'd9);
        checkOutput("same_cnt0", 32'(lq_count), 32'd0);
        tick();
        checkWrite("same_idle", 1'b0, 5'd0, 32'h0);

        $display("[TB] queue fill and drain");
        for (int k = 0; k < 6; k++) begin
            logic [4:0] r;
            r = (k < 4) ? 5'(2 + k) : 5'd6;
            applyStimulus(1'b1, 5'd1, 32'(k), 1'b1, r, 32'h100 + 32'(r));
            checkOutput("fill_ready", 32'(ld_ready), (k < 4) ? 32'd1 : 32'd0);
            tick();
            checkWrite("fill_alu", 1'b1, 5'd1, 32'(k));
            checkOutput("fill_cnt", 32'(lq_count), (k < 4) ? 32'(k + 1) : 32'd4);
        end
        for (int k = 0; k < 5; k++) begin
            drain_rd[k]  = 5'(2 + k);
            drain_val[k] = 32'h102 + 32'(k);
        end
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h106);
        checkOutput("drain_ready0", 32'(ld_ready), 32'd0);
        tick();
        checkWrite("drain0", 1'b1, drain_rd[0], drain_val[0]);
        checkOutput("drain_cnt0", 32'(lq_count), 32'd3);
        checkOutput("drain_ready1", 32'(ld_ready), 32'd1);
        tick();
        checkWrite("drain1", 1'b1, drain_rd[1], drain_val[1]);
        checkOutput("drain_cnt1", 32'(lq_count), 32'd3);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        for (int k = 2; k < 5; k++) begin
            tick();
            checkWrite("drain", 1'b1, drain_rd[k], drain_val[k]);
            checkOutput("drain_cnt", 32'(lq_count), 32'(4 - k));
        end
        tick();
        checkWrite("drain_idle", 1'b0, 5'd0, 32'h0);

        $display("[TB] WAW kill");
        applyStimulus(1'b1, 5'd7, 32'h70, 1'b1, 5'd8, 32'd1);
        tick();
        checkWrite("waw_alu7", 1'b1, 5'd7, 32'h70);
        checkOutput("waw_cnt1", 32'(lq_count), 32'd1);
        applyStimulus(1'b1, 5'd8, 32'd2, 1'b0, 5'd0, 32'h0);
        tick();
        checkWrite("waw_alu8", 1'b1, 5'd8, 32'd2);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        checkWrite("waw_bubble", 1'b0, 5'd0, 32'h0);
        checkOutput("waw_cnt0", 32'(lq_count), 32'd0);
        tick();
        checkWrite("waw_none", 1'b0, 5'd0, 32'h0);

        $display("[TB] forwarding");
        applyStimulus(1'b1, 5'd1, 32'h1, 1'b1, 5'd9, 32'hA);
        tick();
        applyStimulus(1'b1, 5'd2, 32'h2, 1'b1, 5'd9, 32'hB);
        tick();
        checkOutput("fwd_cnt", 32'(lq_count), 32'd2);
        applyStimulus(1'b1, 5'd3, 32'h3, 1'b0, 5'd0, 32'h0);
        rindex0 = 5'd9;
        rindex1 = 5'd0;
        #1;
`ifdef WB_FORWARD_EN
        checkOutput("fwd0_hit_q", 32'(fwd0_hit), 32'd1);
        checkOutput("fwd0_val_q", fwd0_val, 32'hB);
        checkOutput("fwd1_hit_r0", 32'(fwd1_hit), 32'd0);
        rindex1 = 5'd2;
        #1;
        checkOutput("fwd1_hit_reg", 32'(fwd1_hit), 32'd1);
        checkOutput("fwd1_val_reg", fwd1_val, 32'h2);
`else
        checkOutput("fwd0_hit_off", 32'(fwd0_hit), 32'd0);
        checkOutput("fwd0_val_off", fwd0_val, 32'd0);
        checkOutput("fwd1_hit_off", 32'(fwd1_hit), 32'd0);
`endif
        tick();
        applyStimulus(1'b1, 5'd4, 32'h4, 1'b1, 5'd10, 32'hC);
        tick();

        $display("[TB] reset mid-operation");
        checkOutput("pre_rst_cnt", 32'(lq_count), 32'd3);
        checkOutput("pre_rst_we", 32'(we), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_we", 32'(we), 32'd0);
        checkOutput("mid_rst_cnt", 32'(lq_count), 32'd0);
        checkOutput("mid_rst_ready", 32'(ld_ready), 32'd1);
`ifdef WB_FORWARD_EN
        checkOutput("mid_rst_fwd0", 32'(fwd0_hit), 32'd0);
`endif
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        checkWrite("post_rst", 1'b0, 5'd0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
